// File: rtl/time_stopwatch_record_bank_57_pkg.sv
// Shared definitions for the stopwatch lap-record bank.
// Provides the bank geometry, the packed lap record type and the
// pointer helpers used by the bank and its bench.
package time_stopwatch_record_bank_57_pkg;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned W     = 7;
    localparam int unsigned AW    = 3;

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    typedef struct packed {
        logic [W-1:0] hour;
        logic [W-1:0] min;
        logic [W-1:0] sec;
    } rec_t;

    // Next slot index, wrapping DEPTH-1 -> 0.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == DEPTH_A - 1'b1) ? '0 : p + 1'b1;
    endfunction

    // Logical record index -> physical slot. Oldest record sits at wr_ptr
    // once the bank is full, otherwise at slot 0. Only meaningful when
    // addr < count, which keeps the sum below 2*DEPTH so one subtract suffices.
    function automatic logic [AW-1:0] log2phys(input logic [AW-1:0] wr_ptr,
                                                input logic [AW-1:0] count,
                                                input logic [AW-1:0] addr);
        logic [AW:0] oldest;
        logic [AW:0] sum;
        oldest = (count < DEPTH_A) ? '0 : {1'b0, wr_ptr};
        sum    = oldest + {1'b0, addr};
        if (sum >= {1'b0, DEPTH_A}) begin
            sum = sum - {1'b0, DEPTH_A};
        end
        return sum[AW-1:0];
    endfunction

endpackage

// File: rtl/time_stopwatch_record_bank_57.sv
// Lap-record bank feeding the stopwatch record viewer.
// Captures {hour, min, sec} on each lap strobe into a DEPTH-entry circular
// bank (oldest overwritten when full) and serves 1-cycle registered reads
// addressed by logical index (0 = oldest valid record).
// Ports:
//   clk_50m_57, rst_57        clock, synchronous active-high reset
//   rec_e_57, clear_57        lap capture strobe, erase-all strobe
//   stopwatch_*_57            live stopwatch fields to capture
//   read_e_57, read_addr_57   read request and logical index
//   record_stopwatch_*_57     registered read data (held while read_e_57=0)
//   record_valid_57           last read hit a valid record
//   record_count_57           number of valid records, 0..DEPTH
module time_stopwatch_record_bank_57
    import time_stopwatch_record_bank_57_pkg::*;
#(
    parameter int unsigned DEPTH = time_stopwatch_record_bank_57_pkg::DEPTH,
    parameter int unsigned W     = time_stopwatch_record_bank_57_pkg::W
) (
    input  logic         clk_50m_57,
    input  logic         rst_57,
    input  logic         rec_e_57,
    input  logic         clear_57,
    input  logic [W-1:0] stopwatch_sec_57,
    input  logic [W-1:0] stopwatch_min_57,
    input  logic [W-1:0] stopwatch_hour_57,
    input  logic         read_e_57,
    input  logic [2:0]   read_addr_57,
    output logic [W-1:0] record_stopwatch_sec_57,
    output logic [W-1:0] record_stopwatch_min_57,
    output logic [W-1:0] record_stopwatch_hour_57,
    output logic         record_valid_57,
    output logic [2:0]   record_count_57
);

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    rec_t       slots [DEPTH];
    logic [2:0] wr_ptr;
    logic [2:0] count;
    rec_t       rd_data;
    logic       rd_valid;
    logic [2:0] rd_phys;

    assign rd_phys = log2phys(wr_ptr, count, read_addr_57);

    // Pointer, count and slot storage. Clear behaves exactly like reset
    // and swallows any capture in the same cycle.
    always_ff @(posedge clk_50m_57) begin
        if (rst_57 || clear_57) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (rec_e_57) begin
            slots[wr_ptr] <= '{hour: stopwatch_hour_57,
                               min:  stopwatch_min_57,
                               sec:  stopwatch_sec_57};
            wr_ptr <= ptr_inc(wr_ptr);
            if (count != DEPTH_L) begin
                count <= count + 1'b1;
            end
        end
    end

    // Read path samples the pre-edge pointer/count/slots, so a read in the
    // same cycle as a capture returns the old contents.
    always_ff @(posedge clk_50m_57) begin
        if (rst_57 || clear_57) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (read_e_57) begin
            if (read_addr_57 < count) begin
                rd_data  <= slots[rd_phys];
                rd_valid <= 1'b1;
            end else begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end
        end
    end

    assign record_stopwatch_sec_57  = rd_data.sec;
    assign record_stopwatch_min_57  = rd_data.min;
    assign record_stopwatch_hour_57 = rd_data.hour;
    assign record_valid_57          = rd_valid;
    assign record_count_57          = count;

endmodule

// File: tb/tb_time_stopwatch_record_bank_57.sv
// Directed, table-driven bench for time_stopwatch_record_bank_57.
module tb_time_stopwatch_record_bank_57;
    import time_stopwatch_record_bank_57_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         rec_e;
    logic         clr;
    logic [6:0]   sw_sec;
    logic [6:0]   sw_min;
    logic [6:0]   sw_hour;
    logic         rd_e;
    logic [2:0]   rd_addr;
    logic [6:0]   o_sec;
    logic [6:0]   o_min;
    logic [6:0]   o_hour;
    logic         o_valid;
    logic [2:0]   o_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    time_stopwatch_record_bank_57 #(.DEPTH(5), .W(7)) dut (
        .clk_50m_57              (clk),
        .rst_57                  (rst),
        .rec_e_57                (rec_e),
        .clear_57                (clr),
        .stopwatch_sec_57        (sw_sec),
        .stopwatch_min_57        (sw_min),
        .stopwatch_hour_57       (sw_hour),
        .read_e_57               (rd_e),
        .read_addr_57            (rd_addr),
        .record_stopwatch_sec_57 (o_sec),
        .record_stopwatch_min_57 (o_min),
        .record_stopwatch_hour_57(o_hour),
        .record_valid_57         (o_valid),
        .record_count_57         (o_count)
    );

    typedef struct {
        string      name;
        logic       rec;
        logic       clr;
        logic       rd;
        logic [2:0] addr;
        rec_t       t_in;
        logic       exp_valid;
        rec_t       exp_data;
        logic [2:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic rec_t mk(input int h, input int m, input int s);
        rec_t r;
        r.hour = 7'(h);
        r.min  = 7'(m);
        r.sec  = 7'(s);
        return r;
    endfunction

    function automatic rec_t lap(input int k);
        return mk(k, 10 + k, 20 + k);
    endfunction

    function automatic void add(input string name, input logic rec, input logic c,
                                input logic rd, input int addr, input rec_t t_in,
                                input logic ev, input rec_t ed, input int ec);
        vec_t v;
        v.name = name; v.rec = rec; v.clr = c; v.rd = rd; v.addr = 3'(addr);
        v.t_in = t_in; v.exp_valid = ev; v.exp_data = ed; v.exp_count = 3'(ec);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outputs(input string name, input logic ev, input rec_t ed,
                                 input logic [2:0] ec);
        check({name, ".valid"}, int'(o_valid), int'(ev));
        check({name, ".data"}, int'({o_hour, o_min, o_sec}), int'(ed));
        check({name, ".count"}, int'(o_count), int'(ec));
    endtask

    task automatic drive(input logic r, input logic c, input logic rd,
                         input logic [2:0] a, input rec_t t);
        rec_e = r; clr = c; rd_e = rd; rd_addr = a;
        sw_hour = t.hour; sw_min = t.min; sw_sec = t.sec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    rec_t z;

    initial begin
        z = '0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'd0, z);
        step();
        step();
        check_outputs("reset", 1'b0, z, 3'd0);
        rst = 1'b0;

        // Basic capture/read
        add("rd_empty",   0, 0, 1, 0, z,               0, z,              0);
        add("cap_0_01_05",1, 0, 0, 0, mk(0, 1, 5),     0, z,              1);
        add("cap_0_02_10",1, 0, 0, 0, mk(0, 2, 10),    0, z,              2);
        add("rd1",        0, 0, 1, 1, z,               1, mk(0, 2, 10),   2);
        add("hold",       0, 0, 0, 3, z,               1, mk(0, 2, 10),   2);
        add("rd0",        0, 0, 1, 0, z,               1, mk(0, 1, 5),    2);
        add("rd2_inv",    0, 0, 1, 2, z,               0, z,              2);
        add("clear",      0, 1, 0, 0, z,               0, z,              0);
        // Wrap-around
        add("L1", 1, 0, 0, 0, lap(1), 0, z, 1);
        add("L2", 1, 0, 0, 0, lap(2), 0, z, 2);
        add("L3", 1, 0, 0, 0, lap(3), 0, z, 3);
        add("L4", 1, 0, 0, 0, lap(4), 0, z, 4);
        add("L5", 1, 0, 0, 0, lap(5), 0, z, 5);
        add("L6", 1, 0, 0, 0, lap(6), 0, z, 5);
        add("wrap_rd0",   0, 0, 1, 0, z,      1, lap(2), 5);
        add("wrap_rd4",   0, 0, 1, 4, z,      1, lap(6), 5);
        add("wrap_rd7",   0, 0, 1, 7, z,      0, z,      5);
        add("wrap_rd5",   0, 0, 1, 5, z,      0, z,      5);
        // Read concurrent with capture: pre-edge contents
        add("rd4_cap_L7", 1, 0, 1, 4, lap(7), 1, lap(6), 5);
        add("rd4_after",  0, 0, 1, 4, z,      1, lap(7), 5);
        add("rd0_after",  0, 0, 1, 0, z,      1, lap(3), 5);
        // Clear with concurrent capture and read
        add("clr_cap_rd", 1, 1, 1, 0, lap(8), 0, z,      0);
        add("rd0_clred",  0, 0, 1, 0, z,      0, z,      0);
        add("cap_L9",     1, 0, 0, 0, lap(9), 0, z,      1);
        add("rd0_L9",     0, 0, 1, 0, z,      1, lap(9), 1);
        add("rd1_inv",    0, 0, 1, 1, z,      0, z,      1);
        // Fields stored unmodified, no range check
        add("cap_max",    1, 0, 0, 0, mk(127, 127, 127), 0, z,               2);
        add("rd1_max",    0, 0, 1, 1, z,                 1, mk(127,127,127), 2);

        foreach (vecs[i]) begin
            drive(vecs[i].rec, vecs[i].clr, vecs[i].rd, vecs[i].addr, vecs[i].t_in);
            step();
            check_outputs(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data,
                          vecs[i].exp_count);
        end

        // Reset mid-operation during back-to-back captures
        drive(1'b1, 1'b0, 1'b0, 3'd0, lap(20));
        step();
        drive(1'b1, 1'b0, 1'b1, 3'd0, lap(21));
        step();
        check_outputs("pre_rst_rd0", 1'b1, lap(9), 3'd4);
        drive(1'b1, 1'b0, 1'b0, 3'd0, lap(22));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_outputs("mid_rst", 1'b0, z, 3'd0);
        for (int a = 0; a < 5; a++) begin
            drive(1'b0, 1'b0, 1'b1, 3'(a), z);
            step();
            check_outputs($sformatf("post_rst_rd%0d", a), 1'b0, z, 3'd0);
        end

        // Level-sampled strobe: held 3 cycles gives 3 captures
        drive(1'b1, 1'b0, 1'b0, 3'd0, lap(30));
        step(); step(); step();
        drive(1'b0, 1'b0, 1'b1, 3'd2, z);
        step();
        check_outputs("held_rec_rd2", 1'b1, lap(30), 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_stopwatch_record_bank_57.md
# time_stopwatch_record_bank_57

- Lap-record storage sitting directly upstream of the stopwatch record viewer.
- Captures the running stopwatch time (sec/min/hour) on each lap strobe into a 5-entry circular bank.
- Serves registered read requests (read enable + read address) from the viewer.
- Overwrites the oldest entry when full and exposes the number of valid records.

## Interface
Parameters:
- DEPTH, 5, number of lap slots; read addresses 0..DEPTH-1 are valid
- W, 7, width of each time field

Ports:
- clk_50m_57  in  1  system clock, 50 MHz; one clock domain
- rst_57  in  1  reset, synchronous, active-high; clears all state
- rec_e_57  in  1  lap-capture strobe, one cycle per lap, from the stopwatch
- clear_57  in  1  erase all records; single cycle
- stopwatch_sec_57  in  W  current stopwatch seconds
- stopwatch_min_57  in  W  current stopwatch minutes
- stopwatch_hour_57  in  W  current stopwatch hours
- read_e_57  in  1  read request, single cycle
- read_addr_57  in  3  logical record index; 0 = oldest valid record
- record_stopwatch_sec_57  out  W  read-data seconds
- record_stopwatch_min_57  out  W  read-data minutes
- record_stopwatch_hour_57  out  W  read-data hours
- record_valid_57  out  1  1 when the last read hit a valid record
- record_count_57  out  3  number of valid records, 0..DEPTH

## Operation
- **Storage:** DEPTH slots, each holding {hour, min, sec}.
  - wr_ptr_57 (0..DEPTH-1) points at the next slot to write.
  - count_57 (0..DEPTH) is the number of valid records.
- **Capture** (rec_e_57=1, clear_57=0):
  - Slot[wr_ptr] <= current stopwatch fields, stored unmodified with no range check.
  - wr_ptr increments and wraps DEPTH-1 -> 0.
  - count increments and saturates at DEPTH.
  - When full, the write overwrites the oldest record.
- **Logical-to-physical mapping:**
  - oldest = 0 when count < DEPTH, otherwise oldest = wr_ptr.
  - phys = (oldest + read_addr) mod DEPTH.
  - Compute with a single conditional subtract; no divider.
- **Read** (read_e_57=1):
  - If read_addr < count: data outputs <= slot[phys] and record_valid_57 <= 1.
  - Otherwise (including addr 5..7): data outputs <= 0 and record_valid_57 <= 0.
  - When read_e_57=0, data outputs and valid hold their values.
- **Clear** (clear_57=1): every slot, wr_ptr, count, data outputs and valid <= 0.
- **Priority:** rst_57 > clear_57 > capture.
  - A capture in the same cycle as a clear is discarded.
- **Read concurrent with capture:**
  - The read uses the pre-edge count, wr_ptr and slot contents (read-before-write).
  - The captured value is visible to reads from the next cycle.
- **Read concurrent with clear:** the clear wins; outputs are 0 and valid is 0.
- **Reset values:** all outputs 0; all slots 0; wr_ptr 0; count 0.
  - Reset asserted mid-operation discards all records on the next edge.

## Timing
- **Capture:** rec_e_57 sampled at edge N; count and slot update at edge N.
  - record_count_57 shows the new value in cycle N+1.
- **Read latency:** 1 cycle. read_e_57 and read_addr_57 sampled at edge N; data and valid are registered at edge N and held.
  - The viewer registers its read_e/read_addr and copies data every cycle its mode is active. New data is therefore on its inputs one cycle after its read_e pulse.
- **Back-to-back:**
  - rec_e_57 may be asserted on consecutive cycles; each cycle is a separate capture.
  - read_e_57 may be asserted every cycle; each cycle is an independent read.
- **Handshake:** none; no stall or back-pressure.
- **Strobes:** both rec_e_57 and read_e_57 are level-sampled. A strobe held for k cycles performs k operations; upstream must supply single-cycle pulses.

## Structure
- **Shared package:**
  - DEPTH=5, W=7, pointer/address width 3.
  - Packed record typedef {hour, min, sec}.
  - Mod-DEPTH increment function and logical-to-physical mapping function.
- **Sub-module:** none required.
  - The slot array is a flat register array; DEPTH is small, so no RAM inference.
  - The pointer/count logic stays inline in one always block; the read path is in a second block.

## Test plan
- **Reset:** reset -> all outputs 0. Then read addr 0 -> data 0, valid 0, count 0.
- **Basic capture/read:** capture 0:01:05, then 0:02:10 -> count 2. Read addr 1 -> 0:02:10, valid 1, one cycle after read_e. Read addr 2 -> zeros, valid 0.
- **Wrap-around:** capture six laps L1..L6 -> count 5. Read addr 0 -> L2; read addr 4 -> L6; read addr 7 -> zeros, valid 0.
- **Simultaneous read and capture:** with count 5, read addr 4 in the same cycle as capture L7 -> returns L6. Next read addr 4 -> L7.
- **Clear with concurrent capture:** clear in the same cycle as rec_e -> count 0 and all reads invalid. The next capture lands at logical addr 0.
- **Reset mid-operation:** rst during back-to-back captures -> next cycle count 0 and outputs 0; no residual data is readable.
